lm32_intr_ctrl: RTL and testbench
=================================

Name: lm32_intr_ctrl

Overview:
- Wishbone-slave interrupt controller sitting directly upstream of the lm32 core's `interrupt` input vector; also a slave on the core's data Wishbone bus.
- Collects up to INTR_NUM peripheral interrupt lines and latches edge- or level-type requests as pending.
- Applies per-line and global masking, then drives the registered active-high interrupt vector into the core.
- Addressed with the word addresses the lm32 wrapper emits on D_ADR_O.

Parameters:
INTR_NUM  32  number of interrupt lines (1..32); register bits above INTR_NUM-1 read 0, writes ignored
Dw        32  Wishbone data width (fixed 32)
Aw        3   Wishbone word-address width decoded

Ports:
clk_i      in   1         clock
rst_i      in   1         synchronous reset, active-high
int_i      in   INTR_NUM  peripheral interrupt requests, active-high, synchronous to clk_i
sa_dat_i   in   Dw        write data
sa_sel_i   in   4         byte selects
sa_addr_i  in   Aw        word address
sa_stb_i   in   1         strobe
sa_cyc_i   in   1         cycle
sa_we_i    in   1         write enable
sa_dat_o   out  Dw        read data, registered
sa_ack_o   out  1         acknowledge, registered
sa_err_o   out  1         tied 0
sa_rty_o   out  1         tied 0
irq_o      out  INTR_NUM  interrupt vector to lm32 `interrupt`, registered, active-high

Behaviour:
- Reset (rst_i high at a clock edge): all registers 0; sa_ack_o=0, sa_dat_o=0, irq_o=0. Reset mid-transaction drops the ack; the master must reissue the access.
- Register map (word address):
  - 0 STATUS: RO, pending & enable.
  - 1 PENDING: read; write-1-to-clear, edge lines only.
  - 2 ENABLE: RW.
  - 3 EDGE_SEL: RW; 1 = rising-edge, 0 = level.
  - 4 MASTER: RW, bit0 only.
  - 5 SET: WO, write-1 sets pending on edge lines; reads 0.
  - 6, 7: read 0, writes ignored.
- Byte selects mask writes per byte on registers 1–5.
- Bus handshake:
  - Request = sa_stb_i & sa_cyc_i & ~sa_ack_o.
  - On a request edge: sa_ack_o<=1 and sa_dat_o<=selected register (pre-write value); a write commits on the same edge.
  - The next edge always drops ack, so there is one wait-free cycle per access. Back-to-back accesses complete every 2 clocks.
  - With no request, sa_dat_o holds 0.
- Input pipeline:
  - int_q <= int_i; int_p <= int_q.
  - Rising edge detect = int_q & ~int_p.
- Pending, per bit i:
  - Level mode: pending[i] <= int_q[i]. W1C and SET have no effect.
  - Edge mode: set by an edge or a SET write; cleared by a PENDING W1C. Set wins over a simultaneous clear. An edge while already pending is absorbed, with no counting.
  - Changing EDGE_SEL: the next cycle follows the new mode. Edge → level overwrites pending with int_q.
- Output: irq_o <= pending & enable & {INTR_NUM{master}}.
- Latency: int_i rises before edge 1 → int_q=1 after edge 1, pending=1 after edge 2, irq_o=1 after edge 3.
- Level deassertion reaches irq_o after the same 3 edges.
- A W1C committed at edge n drops irq_o after edge n+1.
- Clearing ENABLE or MASTER at edge n drops irq_o after edge n+1.
- Pending stays latched while masked; re-enabling re-asserts irq_o one edge after the enable write.

Test Plan:
- Reset: hold rst_i 2 cycles while int_i=all-ones and stb asserted → irq_o=0, sa_ack_o=0, sa_dat_o=0; all registers read 0 afterwards.
- Level line: ENABLE=0x1, MASTER=1, EDGE_SEL=0. Pulse int_i[0] high for 5 cycles → irq_o[0] high exactly 5 cycles, starting 3 edges after the rise. W1C of PENDING has no effect.
- Edge line: EDGE_SEL=0x4, ENABLE=0x4, MASTER=1. 1-cycle pulse on int_i[2] → irq_o=0x4 after 3 edges and held; PENDING reads 0x4. Write 0x4 to addr 1 → irq_o=0 one edge after the ack.
- Simultaneous set/clear: int_i[2] edge timed to reach pending on the same edge as a W1C of bit 2 → PENDING remains 0x4.
- Masking: edge line 3 pending with ENABLE=0 → irq_o=0, STATUS=0, PENDING=0x8. Write ENABLE=0x8 → irq_o=0x8 one edge later. MASTER=0 → irq_o=0 one edge later.
- Bus protocol: stb/cyc held for 4 cycles on a read of addr 2 → ack pattern 1,0,1,0 with data valid on ack cycles. Byte-select write sel=0x2, data 0xFFFFFFFF to ENABLE → reads 0x0000FF00. Read addr 5, 6, 7 → 0.

Source files
------------

// File: rtl/lm32_intr_ctrl_if.sv
// Wishbone slave bundle between the lm32 data bus and the interrupt controller.
interface lm32_intr_ctrl_if #(
    parameter int Dw = 32,
    parameter int Aw = 3
);
    logic [Dw-1:0] sa_dat_i;
    logic [3:0]    sa_sel_i;
    logic [Aw-1:0] sa_addr_i;
    logic          sa_stb_i;
    logic          sa_cyc_i;
    logic          sa_we_i;
    logic [Dw-1:0] sa_dat_o;
    logic          sa_ack_o;
    logic          sa_err_o;
    logic          sa_rty_o;

    modport master (
        output sa_dat_i, sa_sel_i, sa_addr_i, sa_stb_i, sa_cyc_i, sa_we_i,
        input  sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
    );

    modport slave (
        input  sa_dat_i, sa_sel_i, sa_addr_i, sa_stb_i, sa_cyc_i, sa_we_i,
        output sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
    );
endinterface

// File: rtl/lm32_intr_ctrl.sv
// Interrupt controller for the lm32 core: latches edge/level requests as pending,
// masks them per line and globally, and drives the registered interrupt vector.
module lm32_intr_ctrl #(
    parameter int INTR_NUM = 32,
    parameter int Dw       = 32,
    parameter int Aw       = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [INTR_NUM-1:0] int_i,
    output logic [INTR_NUM-1:0] irq_o,
    lm32_intr_ctrl_if.slave     bus
);
    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_PENDING = 3'd1;
    localparam logic [2:0] A_ENABLE  = 3'd2;
    localparam logic [2:0] A_EDGE    = 3'd3;
    localparam logic [2:0] A_MASTER  = 3'd4;
    localparam logic [2:0] A_SET     = 3'd5;

    logic [INTR_NUM-1:0] int_q, int_p;
    logic [INTR_NUM-1:0] pending, enable, edge_sel;
    logic                master;
    logic [INTR_NUM-1:0] pend_nxt, set_bits, clr_bits;
    logic [INTR_NUM-1:0] wmask, wdat;
    logic [Dw-1:0]       bmask, rd_dat;
    logic [Aw-1:0]       adr;
    logic                req, wr;
    logic                wr_pend, wr_en, wr_edge, wr_master, wr_set;

    assign bus.sa_err_o = 1'b0;
    assign bus.sa_rty_o = 1'b0;

    assign adr   = bus.sa_addr_i;
    assign req   = bus.sa_stb_i & bus.sa_cyc_i & ~bus.sa_ack_o;
    assign wr    = req & bus.sa_we_i;
    assign bmask = {{8{bus.sa_sel_i[3]}}, {8{bus.sa_sel_i[2]}},
                    {8{bus.sa_sel_i[1]}}, {8{bus.sa_sel_i[0]}}};
    assign wmask = bmask[INTR_NUM-1:0];
    assign wdat  = bus.sa_dat_i[INTR_NUM-1:0];

    assign wr_pend   = wr && (adr == A_PENDING);
    assign wr_en     = wr && (adr == A_ENABLE);
    assign wr_edge   = wr && (adr == A_EDGE);
    assign wr_master = wr && (adr == A_MASTER);
    assign wr_set    = wr && (adr == A_SET);

    // Set beats clear on edge lines; level lines simply mirror the synchronised input.
    always_comb begin
        set_bits = int_q & ~int_p;
        clr_bits = '0;
        if (wr_set)
            set_bits = set_bits | (wdat & wmask);
        if (wr_pend)
            clr_bits = wdat & wmask;
        pend_nxt = (edge_sel & ((pending & ~clr_bits) | set_bits)) | (~edge_sel & int_q);
    end

    always_comb begin
        rd_dat = '0;
        case (adr)
            A_STATUS:  rd_dat[INTR_NUM-1:0] = pending & enable;
            A_PENDING: rd_dat[INTR_NUM-1:0] = pending;
            A_ENABLE:  rd_dat[INTR_NUM-1:0] = enable;
            A_EDGE:    rd_dat[INTR_NUM-1:0] = edge_sel;
            A_MASTER:  rd_dat[0]            = master;
            default:   rd_dat               = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            int_q        <= '0;
            int_p        <= '0;
            pending      <= '0;
            enable       <= '0;
            edge_sel     <= '0;
            master       <= 1'b0;
            irq_o        <= '0;
            bus.sa_ack_o <= 1'b0;
            bus.sa_dat_o <= '0;
        end else begin
            int_q   <= int_i;
            int_p   <= int_q;
            pending <= pend_nxt;
            irq_o   <= pending & enable & {INTR_NUM{master}};
            if (wr_en)
                enable <= (enable & ~wmask) | (wdat & wmask);
            if (wr_edge)
                edge_sel <= (edge_sel & ~wmask) | (wdat & wmask);
            if (wr_master && bus.sa_sel_i[0])
                master <= bus.sa_dat_i[0];
            bus.sa_ack_o <= req;
            bus.sa_dat_o <= req ? rd_dat : '0;
        end
    end
endmodule

// File: tb/tb_lm32_intr_ctrl.sv
// Directed bench for lm32_intr_ctrl: register table plus timing sequences.
module tb_lm32_intr_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] int_i = '0;
    logic [31:0] irq;
    int          n_chk = 0;
    int          n_fail = 0;

    lm32_intr_ctrl_if #(.Dw(32), .Aw(3)) bus ();

    lm32_intr_ctrl #(.INTR_NUM(32), .Dw(32), .Aw(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .int_i (int_i),
        .irq_o (irq),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vec[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                      input logic [3:0] sel, output logic [31:0] rdata);
        logic got;
        got = 1'b0;
        rdata = '0;
        bus.sa_we_i   = we;
        bus.sa_addr_i = addr;
        bus.sa_dat_i  = wdata;
        bus.sa_sel_i  = sel;
        bus.sa_stb_i  = 1'b1;
        bus.sa_cyc_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.sa_ack_o === 1'b1) begin
                got = 1'b1;
                rdata = bus.sa_dat_o;
                break;
            end
        end
        bus.sa_stb_i = 1'b0;
        bus.sa_cyc_i = 1'b0;
        bus.sa_we_i  = 1'b0;
        chk("wb_ack_seen", {31'b0, got}, 32'd1);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] d);
        logic [31:0] r;
        wb(1'b1, addr, d, 4'hF, r);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        wb(1'b0, addr, 32'h0, 4'hF, r);
        chk(name, r, exp);
    endtask

    initial begin
        logic [31:0] r;

        vec[0]  = '{1'b1, 3'd2, 32'hA5A5A5A5, 4'hF, 32'h00000000};
        vec[1]  = '{1'b0, 3'd2, 32'h00000000, 4'hF, 32'hA5A5A5A5};
        vec[2]  = '{1'b1, 3'd2, 32'h00000000, 4'hF, 32'hA5A5A5A5};
        vec[3]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 4'h2, 32'h00000000};
        vec[4]  = '{1'b0, 3'd2, 32'h00000000, 4'hF, 32'h0000FF00};
        vec[5]  = '{1'b1, 3'd3, 32'hFFFFFFFF, 4'hC, 32'h00000000};
        vec[6]  = '{1'b0, 3'd3, 32'h00000000, 4'hF, 32'hFFFF0000};
        vec[7]  = '{1'b1, 3'd4, 32'hFFFFFFFF, 4'h1, 32'h00000000};
        vec[8]  = '{1'b0, 3'd4, 32'h00000000, 4'hF, 32'h00000001};
        vec[9]  = '{1'b1, 3'd4, 32'hFFFFFFFE, 4'hF, 32'h00000001};
        vec[10] = '{1'b0, 3'd4, 32'h00000000, 4'hF, 32'h00000000};
        vec[11] = '{1'b1, 3'd6, 32'hFFFFFFFF, 4'hF, 32'h00000000};
        vec[12] = '{1'b0, 3'd6, 32'h00000000, 4'hF, 32'h00000000};
        vec[13] = '{1'b1, 3'd5, 32'h00000000, 4'hF, 32'h00000000};
        vec[14] = '{1'b0, 3'd5, 32'h00000000, 4'hF, 32'h00000000};
        vec[15] = '{1'b0, 3'd7, 32'h00000000, 4'hF, 32'h00000000};
        vec[16] = '{1'b1, 3'd3, 32'h00000000, 4'hF, 32'hFFFF0000};
        vec[17] = '{1'b1, 3'd2, 32'h00000000, 4'hF, 32'h0000FF00};
        vec[18] = '{1'b0, 3'd0, 32'h00000000, 4'hF, 32'h00000000};

        // Reset with everything shouting
        int_i = '1;
        bus.sa_dat_i = '0; bus.sa_sel_i = 4'hF; bus.sa_addr_i = 3'd2;
        bus.sa_we_i = 1'b0; bus.sa_stb_i = 1'b1; bus.sa_cyc_i = 1'b1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_irq", irq, 32'h0);
            chk("rst_ack", {31'b0, bus.sa_ack_o}, 32'h0);
            chk("rst_dat", bus.sa_dat_o, 32'h0);
        end
        rst = 1'b0;
        int_i = '0;
        bus.sa_stb_i = 1'b0; bus.sa_cyc_i = 1'b0;
        tick();
        for (int a = 0; a < 8; a++)
            rd_chk($sformatf("rst_reg%0d", a), 3'(a), 32'h0);

        // Register table
        for (int i = 0; i < 19; i++) begin
            wb(vec[i].we, vec[i].addr, vec[i].wdata, vec[i].sel, r);
            chk($sformatf("vec%0d_rd", i), r, vec[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), irq, 32'h0);
        end

        // Level line 0: 5-cycle pulse gives 5 cycles of irq starting 3 edges later
        wr(3'd2, 32'h1);
        wr(3'd4, 32'h1);
        tick();
        int_i = 32'h1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) int_i = 32'h0;
            chk($sformatf("lvl_irq_e%0d", k), irq, (k >= 3 && k <= 7) ? 32'h1 : 32'h0);
        end
        int_i = 32'h1;
        repeat (4) tick();
        wr(3'd1, 32'h1);
        tick(); tick();
        chk("lvl_w1c_irq", irq, 32'h1);
        rd_chk("lvl_w1c_pend", 3'd1, 32'h1);
        int_i = 32'h0;
        repeat (4) tick();
        chk("lvl_drop_irq", irq, 32'h0);

        // SET register on an edge line
        wr(3'd3, 32'h10);
        wr(3'd5, 32'h10);
        rd_chk("set_pend", 3'd1, 32'h10);
        wr(3'd1, 32'h10);
        rd_chk("set_clr_pend", 3'd1, 32'h0);

        // Edge line 2
        wr(3'd3, 32'h4);
        wr(3'd2, 32'h4);
        tick();
        int_i = 32'h4;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) int_i = 32'h0;
            chk($sformatf("edge_irq_e%0d", k), irq, (k >= 3) ? 32'h4 : 32'h0);
        end
        rd_chk("edge_pend", 3'd1, 32'h4);
        wr(3'd1, 32'h4);
        chk("edge_w1c_irq_at_ack", irq, 32'h4);
        tick();
        chk("edge_w1c_irq_after", irq, 32'h0);

        // Edge reaching pending on the same edge as the W1C commit
        tick();
        int_i = 32'h4;
        tick();
        int_i = 32'h0;
        bus.sa_we_i = 1'b1; bus.sa_addr_i = 3'd1; bus.sa_dat_i = 32'h4;
        bus.sa_sel_i = 4'hF; bus.sa_stb_i = 1'b1; bus.sa_cyc_i = 1'b1;
        tick();
        chk("simul_ack", {31'b0, bus.sa_ack_o}, 32'h1);
        bus.sa_stb_i = 1'b0; bus.sa_cyc_i = 1'b0; bus.sa_we_i = 1'b0;
        rd_chk("simul_pend", 3'd1, 32'h4);
        wr(3'd1, 32'h4);
        rd_chk("simul_clr_pend", 3'd1, 32'h0);

        // Masking on edge line 3
        wr(3'd2, 32'h0);
        wr(3'd3, 32'h8);
        tick();
        int_i = 32'h8;
        tick();
        int_i = 32'h0;
        repeat (4) tick();
        chk("mask_irq", irq, 32'h0);
        rd_chk("mask_status", 3'd0, 32'h0);
        rd_chk("mask_pend", 3'd1, 32'h8);
        wr(3'd2, 32'h8);
        chk("mask_en_irq_at_ack", irq, 32'h0);
        tick();
        chk("mask_en_irq_after", irq, 32'h8);
        rd_chk("mask_status_en", 3'd0, 32'h8);
        wr(3'd4, 32'h0);
        chk("mask_mst_irq_at_ack", irq, 32'h8);
        tick();
        chk("mask_mst_irq_after", irq, 32'h0);

        // Held strobe: ack toggles every other cycle
        bus.sa_we_i = 1'b0; bus.sa_addr_i = 3'd2; bus.sa_sel_i = 4'hF;
        bus.sa_stb_i = 1'b1; bus.sa_cyc_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("hold_ack%0d", k), {31'b0, bus.sa_ack_o}, (k % 2 == 1) ? 32'h1 : 32'h0);
            chk($sformatf("hold_dat%0d", k), bus.sa_dat_o, (k % 2 == 1) ? 32'h8 : 32'h0);
        end
        bus.sa_stb_i = 1'b0; bus.sa_cyc_i = 1'b0;
        tick();
        chk("idle_ack", {31'b0, bus.sa_ack_o}, 32'h0);
        chk("err_rty", {30'b0, bus.sa_err_o, bus.sa_rty_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
